// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART widths, defaults and byte type
package uartUtil;

  localparam int UART_DATA_W                = 8;
  localparam int UART_RX_FIFO_DEPTH_DEFAULT = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x byte storage, sync write, async read, no reset
module uart_fifo_mem
  import uartUtil::*;
#(
  parameter int  DEPTH  = UART_RX_FIFO_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  uart_byte_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output uart_byte_t        rdata
);

  uart_byte_t mem [DEPTH];

  // write port: contents are never reset, occupancy lives in the pointers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with overflow flag; optional UART_RX_FIFO_ALMOST_FULL_EN
module uart_rx_fifo
  import uartUtil::*;
#(
  parameter int  DEPTH  = UART_RX_FIFO_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int  AF_THRESHOLD = DEPTH - 2
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  uart_byte_t      rxByte,
  input  logic            rxDone,
  output uart_byte_t      dataOut,
  output logic            dataValid,
  input  logic            dataReady,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  input  logic            clearOverflow
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic            almostFull
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            done_dly;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic            push_drop;
  uart_byte_t      mem_rdata;

  // a frame is counted once, on the rising edge of the receiver's done level
  assign push      = rxDone & ~done_dly;
  assign pop       = dataValid & dataReady;
  // a full FIFO still takes the byte when a pop frees a slot in the same cycle
  assign push_ok   = push & (~full | pop);
  assign push_drop = push & full & ~pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign dataValid = ~empty;
  assign dataOut   = dataValid ? mem_rdata : '0;

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (rxByte),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // rxDone history for edge detection; cleared so a held level re-pushes after reset
  always_ff @(posedge clk) begin
    if (rst) done_dly <= 1'b0;
    else     done_dly <= rxDone;
  end

  // extra-MSB pointers wrap naturally modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // sticky drop flag; a drop in the same cycle beats the host's clear
  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (push_drop)     overflow <= 1'b1;
    else if (clearOverflow) overflow <= 1'b0;
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic [ADDR_W:0] count_next;

  assign count_next = count + (push_ok ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);

  // registered early-drain hint tracking the occupancy after this edge
  always_ff @(posedge clk) begin
    if (rst) almostFull <= 1'b0;
    else     almostFull <= (count_next >= (ADDR_W+1)'(AF_THRESHOLD));
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxByte = 8'h00;
  logic       rxDone = 1'b0;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clearOverflow = 1'b0;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almostFull;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: plain byte queue, sticky flag, previous rxDone level
  logic [7:0] m_q[$];
  logic [7:0] m_out[$];
  logic       m_ovf  = 1'b0;
  logic       m_prev = 1'b0;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .rxByte        (rxByte),
    .rxDone        (rxDone),
    .dataOut       (dataOut),
    .dataValid     (dataValid),
    .dataReady     (dataReady),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .clearOverflow (clearOverflow)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almostFull    (almostFull)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic hold_done);
    rst    = 1'b1;
    rxDone = hold_done;
    dataReady = 1'b0;
    clearOverflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_out.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endtask

  // one clock: drive inputs, advance, apply the FIFO rules to the model
  task automatic step(input logic d, input logic [7:0] b, input logic r, input logic c);
    logic push, pop;
    logic [7:0] tmp;
    rxDone = d; rxByte = b; dataReady = r; clearOverflow = c;
    @(posedge clk);
    push = d && !m_prev;
    pop  = (m_q.size() != 0) && r;
    if (pop) begin
      tmp = m_q.pop_front();
      m_out.push_back(tmp);
    end
    if (push && m_q.size() < 16) m_q.push_back(b);
    else if (push)               m_ovf = 1'b1;
    else if (c)                  m_ovf = 1'b0;
    if (push && m_q.size() <= 16 && c && !(m_ovf && push && m_q.size() == 16 && !pop)) begin
      if (!(push && !pop && m_q.size() == 16 && m_ovf)) m_ovf = 1'b0;
    end
    m_prev = d;
    #1;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dataValid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL reset_dataout got %02h want 00", dataOut); end
  endtask

  task automatic test_multi_cycle_done;
    do_reset(1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (dataOut !== 8'hA5 || dataValid !== 1'b1) begin errors++; $display("FAIL hold_first got %02h/%0b want a5/1", dataOut, dataValid); end
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL hold_count got %0d want 1", count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || m_out.size() != 1 || m_out[0] !== 8'hA5) begin errors++; $display("FAIL hold_drain got empty=%0b want 1", empty); end
  endtask

  task automatic test_fill_overflow;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %0b want 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dataOut !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d] got %02h want %02h", i, dataOut, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1 || dataOut !== 8'h00) begin errors++; $display("FAIL fill_drained got empty=%0b out=%02h want 1/00", empty, dataOut); end
  endtask

  task automatic test_full_push_pop;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    step(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpp_count got %0d want 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got %0b want 0", overflow); end
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (dataOut !== 8'h55 || count !== 5'd1) begin errors++; $display("FAIL fullpp_last got %02h cnt %0d want 55 cnt 1", dataOut, count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    logic [7:0] sent[$];
    logic [7:0] b;
    int max_cnt = 0;
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      step(1'b1, b, 1'b1, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      checks++; if (dataOut !== b) begin errors++; $display("FAIL wrap_data[%0d] got %02h want %02h", i, dataOut, b); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    checks++; if (max_cnt > 1) begin errors++; $display("FAIL wrap_maxcount got %0d want <=1", max_cnt); end
    checks++; if (m_out != sent || empty !== 1'b1) begin errors++; $display("FAIL wrap_order got %0d bytes want %0d", m_out.size(), sent.size()); end
  endtask

  task automatic test_clear_overflow;
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i + 8'h30), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_set got %0b want 1", overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got %0b want 0", overflow); end
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop got %0b want 1", overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    for (int i = 16; i > 0; i--) begin
      checks++; if (almostFull !== (i >= 14)) begin errors++; $display("FAIL af_at_%0d got %0b want %0b", i, almostFull, (i >= 14)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    do_reset(1'b1);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", count); end
    step(1'b1, 8'h33, 1'b0, 1'b0);
    checks++; if (count !== 5'd1 || dataOut !== 8'h33) begin errors++; $display("FAIL rstmid_repush got %0d/%02h want 1/33", count, dataOut); end
  endtask

  task automatic test_random;
    logic d = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) d = ~d;
      step(d, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      checks++;
      if (count !== 5'(m_q.size()) || dataValid !== (m_q.size() != 0) || empty !== (m_q.size() == 0) ||
          full !== (m_q.size() == 16) || overflow !== m_ovf ||
          dataOut !== ((m_q.size() != 0) ? m_q[0] : 8'h00)) begin
        errors++;
        $display("FAIL random[%0d] got cnt=%0d out=%02h ovf=%0b full=%0b want cnt=%0d out=%02h ovf=%0b",
                 i, count, dataOut, overflow, full, m_q.size(),
                 (m_q.size() != 0) ? m_q[0] : 8'h00, m_ovf);
      end
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      checks++; if (almostFull !== (m_q.size() >= 14)) begin errors++; $display("FAIL random_af[%0d] got %0b want %0b", i, almostFull, (m_q.size() >= 14)); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_multi_cycle_done;
    test_fill_overflow;
    test_full_push_pop;
    test_wrap;
    test_clear_overflow;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
